// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Groups the requester-side and grant-side signals of the shared bus arbiter.
//   req       : per-requester bus request (level)
//   lock      : per-requester lock, exempts the current owner from the hold cap
//   din       : flattened requester data, slice i = din[i*W +: W]
//   gnt       : registered one-hot grant
//   gnt_valid : any grant active
//   gnt_id    : index of the owner (holds the last owner while idle)
//   bus       : owner's data slice, 0 when nobody owns the bus
//   handoff   : high during the dead cycle between owners
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*W-1:0]  din;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [W-1:0]    bus;
  logic            handoff;

  modport master (
    output req, lock, din,
    input  gnt, gnt_valid, gnt_id, bus, handoff
  );

  modport slave (
    input  req, lock, din,
    output gnt, gnt_valid, gnt_id, bus, handoff
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter and data multiplexer for the CPU's shared W-bit bus.
// Exactly one requester (or none) drives the bus; a one-cycle dead slot is
// inserted between owners, and an unlocked owner is evicted after MAX_HOLD
// cycles when another requester is waiting (MAX_HOLD = 0 disables the cap).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bif   : bus_arbiter_if.slave (req/lock/din in; gnt/gnt_valid/gnt_id/
//           bus/handoff out)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bif
);

  localparam int ID_W = (N > 1) ? $clog2(N) : 1;
  // hold_cnt only ever counts 0 .. MAX_HOLD-1
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [ID_W-1:0] owner_q,  owner_d;
  logic [ID_W-1:0] ptr_q,    ptr_d;
  logic [HC_W-1:0] hold_q,   hold_d;
  logic [N-1:0]    gnt_q,    gnt_d;

  logic            any_req;
  logic            others_req;
  logic            expire;
  logic [ID_W-1:0] winner;
  logic [W-1:0]    bus_mux;

  // Lowest i such that requester (p+i) mod N is requesting.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [ID_W-1:0] p);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(p) + i) % N;
      if (!found && r[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] o);
    return (int'(o) == N - 1) ? '0 : ID_W'(int'(o) + 1);
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt_d      = gnt_q;

    any_req    = |bif.req;
    winner     = rr_pick(bif.req, ptr_q);
    // The evicted owner's own req never counts as contention.
    others_req = |(bif.req & ~gnt_q);
    expire     = (MAX_HOLD != 0) && !bif.lock[owner_q] &&
                 (hold_q == HOLD_LAST) && others_req;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d         = OWNED;
          owner_d         = winner;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          hold_d          = '0;
        end
      end

      OWNED: begin
        // Voluntary drop and expiry share this single path, so ptr
        // advances only once even when both happen on the same edge.
        if (!bif.req[owner_q] || expire) begin
          state_d = HANDOFF;
          gnt_d   = '0;
          ptr_d   = next_idx(owner_q);
          hold_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d  = hold_q + 1'b1;
        end
      end

      HANDOFF: begin
        // ptr_q already points past the previous owner here.
        if (any_req) begin
          state_d         = OWNED;
          owner_d         = winner;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          hold_d          = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  // Bus mux keyed only by the registered one-hot grant, so din can never
  // influence arbitration and the bus is 0 whenever gnt is 0.
  always_comb begin
    bus_mux = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        bus_mux = bus_mux | bif.din[i*W +: W];
      end
    end
  end

  assign bif.gnt       = gnt_q;
  assign bif.gnt_valid = |gnt_q;
  assign bif.gnt_id    = owner_q;
  assign bif.bus       = bus_mux;
  assign bif.handoff   = (state_q == HANDOFF);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam logic [31:0] DIN0 = 32'h44A5_2211;
  localparam logic [31:0] DIN1 = 32'h445A_2211;

  logic clk;
  logic reset;

  bus_arbiter_if #(.N(N), .W(W)) ba ();
  bus_arbiter_if #(.N(N), .W(W)) bb ();

  bus_arbiter #(.N(N), .W(W), .MAX_HOLD(8)) dut_a (.clk(clk), .reset(reset), .bif(ba));
  bus_arbiter #(.N(N), .W(W), .MAX_HOLD(2)) dut_b (.clk(clk), .reset(reset), .bif(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_STEP, K_RST_ON, K_RST_OFF} kind_t;

  typedef struct {
    kind_t       kind;
    int          sel;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        hof;
    string       name;
  } vec_t;

  typedef struct {
    int          sel;
    logic [3:0]  gnt;
    logic        hof;
    logic [31:0] din;
    string       name;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] last_id [2];

  task automatic add(input kind_t k, input int sel, input logic [3:0] r,
                     input logic [3:0] l, input logic [31:0] d,
                     input logic [3:0] g, input logic h, input string nm);
    vec_t v;
    v.kind = k; v.sel = sel; v.req = r; v.lock = l; v.din = d;
    v.gnt = g; v.hof = h; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.sel == 0) begin
      ba.req = v.req; ba.lock = v.lock; ba.din = v.din;
      bb.req = '0;    bb.lock = '0;
    end else begin
      bb.req = v.req; bb.lock = v.lock; bb.din = v.din;
      ba.req = '0;    ba.lock = '0;
    end
  endtask

  task automatic push_exp(input vec_t v, input logic [3:0] g, input logic h);
    exp_t e;
    e.sel = v.sel; e.gnt = g; e.hof = h; e.din = v.din; e.name = v.name;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t       e;
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    logic [7:0] b;
    logic       h;
    logic [1:0] eid;
    logic [7:0] eb;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel == 0) begin
      g = ba.gnt; v = ba.gnt_valid; id = ba.gnt_id; b = ba.bus; h = ba.handoff;
    end else begin
      g = bb.gnt; v = bb.gnt_valid; id = bb.gnt_id; b = bb.bus; h = bb.handoff;
    end
    eid = last_id[e.sel];
    eb  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (e.gnt[i]) begin
        eid = 2'(i);
        eb  = e.din[i*8 +: 8];
      end
    end
    last_id[e.sel] = eid;
    check({e.name, ".gnt"},       32'(g),  32'(e.gnt));
    check({e.name, ".gnt_valid"}, 32'(v),  32'(|e.gnt));
    check({e.name, ".gnt_id"},    32'(id), 32'(eid));
    check({e.name, ".bus"},       32'(b),  32'(eb));
    check({e.name, ".handoff"},   32'(h),  32'(e.hof));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       v;
    logic [3:0] g;
    int         pos;
    int         own;

    reset   = 1'b0;
    ba.req  = '0; ba.lock = '0; ba.din = DIN0;
    bb.req  = '0; bb.lock = '0; bb.din = DIN0;
    last_id[0] = '0;
    last_id[1] = '0;

    // Reset held with all requests, then release into continuous round robin.
    add(K_RST_ON, 0, 4'b1111, 4'b0000, DIN0, 4'b0000, 1'b0, "rst_now");
    for (int i = 0; i < 3; i++)
      add(K_STEP, 0, 4'b1111, 4'b0000, DIN0, 4'b0000, 1'b0, "rst_hold");
    add(K_RST_OFF, 0, 4'b1111, 4'b0000, DIN0, 4'b0000, 1'b0, "rst_rel");
    // 8 owned cycles then one dead cycle per owner, owners 0,1,2,3,0.
    for (int c = 0; c < 37; c++) begin
      pos = c % 9;
      own = (c / 9) % 4;
      g   = '0;
      if (pos < 8) g[own] = 1'b1;
      add(K_STEP, 0, 4'b1111, 4'b0000, DIN0, g, (pos == 8), "rr");
    end

    // Voluntary release by a single requester, longer than MAX_HOLD.
    add(K_RST_ON,  0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "vol_rst");
    add(K_RST_OFF, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "vol_rel");
    for (int i = 0; i < 12; i++)
      add(K_STEP, 0, 4'b0100, 4'b0000, (i < 6) ? DIN0 : DIN1, 4'b0100, 1'b0, "vol_own");
    add(K_STEP, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b1, "vol_hof");
    add(K_STEP, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "vol_idle");
    add(K_STEP, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "vol_idle2");

    // Locked owner under contention, then lock dropped with hold saturated.
    add(K_RST_ON,  0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "lk_rst");
    add(K_RST_OFF, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "lk_rel");
    add(K_STEP, 0, 4'b0010, 4'b0110, DIN0, 4'b0010, 1'b0, "lk_grant");
    for (int i = 0; i < 20; i++)
      add(K_STEP, 0, 4'b0011, 4'b0010, DIN0, 4'b0010, 1'b0, "lk_hold");
    add(K_STEP, 0, 4'b0011, 4'b0000, DIN0, 4'b0000, 1'b1, "lk_drop");
    add(K_STEP, 0, 4'b0011, 4'b0000, DIN0, 4'b0001, 1'b0, "lk_next");

    // Mid-ownership reset of owner 3 while ptr sits at 2.
    add(K_RST_ON,  0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "mr_rst");
    add(K_RST_OFF, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "mr_rel");
    add(K_STEP, 0, 4'b0010, 4'b0000, DIN0, 4'b0010, 1'b0, "mr_own1");
    add(K_STEP, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b1, "mr_hof");
    add(K_STEP, 0, 4'b1000, 4'b0000, DIN0, 4'b1000, 1'b0, "mr_own3");
    add(K_RST_ON,  0, 4'b1000, 4'b0000, DIN0, 4'b0000, 1'b0, "mr_mid");
    add(K_RST_OFF, 0, 4'b1000, 4'b0000, DIN0, 4'b0000, 1'b0, "mr_rel2");
    add(K_STEP, 0, 4'b1000, 4'b0000, DIN0, 4'b1000, 1'b0, "mr_regrant");
    // Same setup, released with all requests: ptr back at 0 picks requester 0.
    add(K_STEP, 0, 4'b0010, 4'b0000, DIN0, 4'b0000, 1'b1, "mp_hof0");
    add(K_STEP, 0, 4'b0010, 4'b0000, DIN0, 4'b0010, 1'b0, "mp_own1");
    add(K_STEP, 0, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b1, "mp_hof");
    add(K_STEP, 0, 4'b1000, 4'b0000, DIN0, 4'b1000, 1'b0, "mp_own3");
    add(K_RST_ON,  0, 4'b1111, 4'b0000, DIN0, 4'b0000, 1'b0, "mp_mid");
    add(K_RST_OFF, 0, 4'b1111, 4'b0000, DIN0, 4'b0000, 1'b0, "mp_rel");
    add(K_STEP, 0, 4'b1111, 4'b0000, DIN0, 4'b0001, 1'b0, "mp_ptr0");

    // MAX_HOLD=2: owner 0 drops req on its expiry edge -> one handoff only.
    add(K_RST_ON,  1, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "sx_rst");
    add(K_RST_OFF, 1, 4'b0000, 4'b0000, DIN0, 4'b0000, 1'b0, "sx_rel");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0001, 1'b0, "sx_own0a");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0001, 1'b0, "sx_own0b");
    add(K_STEP, 1, 4'b0010, 4'b0000, DIN0, 4'b0000, 1'b1, "sx_hof");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0010, 1'b0, "sx_own1a");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0010, 1'b0, "sx_own1b");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0000, 1'b1, "sx_hof2");
    add(K_STEP, 1, 4'b0011, 4'b0000, DIN0, 4'b0001, 1'b0, "sx_own0c");
    // Lone requester never expires.
    add(K_STEP, 1, 4'b0001, 4'b0000, DIN0, 4'b0001, 1'b0, "sx_lone");
    for (int i = 0; i < 4; i++)
      add(K_STEP, 1, 4'b0001, 4'b0000, DIN0, 4'b0001, 1'b0, "sx_lone");

    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      v = vecs[k];
      case (v.kind)
        K_STEP: begin
          drive(v);
          push_exp(v, v.gnt, v.hof);
          @(posedge clk);
          #1;
          sample();
        end
        K_RST_ON: begin
          drive(v);
          reset = 1'b0;
          last_id[0] = '0;
          last_id[1] = '0;
          push_exp(v, 4'b0000, 1'b0);
          #1;
          sample();
        end
        default: begin
          drive(v);
          reset = 1'b1;
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and data multiplexer for the CPU's shared 8-bit bus. It lets N requesters take turns driving the bus: the core's register-transfer path, a debug/loader port, and future DMA. It keeps exactly one driver (or none) at any time, inserts a dead cycle between owners, and caps how long an unlocked owner may hold the bus while others are waiting. It sits between the requester outputs and the bus net that feeds the accumulator, the GPRs and the IR.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, bus/data width
- MAX_HOLD, 8, cycles an unlocked owner may keep the bus while another request is pending; 0 disables the limit
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  N  per-requester bus request, level
- lock  in  N  per-requester lock; exempts the current owner from the MAX_HOLD limit
- din  in  N*W  flattened requester data; slice i = din[i*W +: W]
- gnt  out  N  one-hot grant, registered
- gnt_valid  out  1  high when any grant is active (OR of gnt)
- gnt_id  out  max(1,$clog2(N))  index of the owner; holds the last owner when gnt_valid=0
- bus  out  W  din slice of the owner when gnt_valid=1, else 0
- handoff  out  1  high during the dead cycle between owners

## Operation
- The FSM has three states: IDLE, OWNED and HANDOFF.
- IDLE:
  - If any req is high at a rising edge, the winner is chosen round-robin starting from ptr.
  - gnt[winner] goes high and the state moves to OWNED.
  - hold_cnt is cleared.
- OWNED:
  - If req[owner] is low at the edge, the state moves to HANDOFF.
  - Forced release: if lock[owner]=0, MAX_HOLD≠0, hold_cnt==MAX_HOLD-1 and any other req is high, the state moves to HANDOFF.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1.
- HANDOFF:
  - gnt=0, bus=0 and handoff=1 for exactly one cycle.
  - ptr becomes (old owner+1) mod N.
  - At the next edge the state moves to OWNED if any req is high (winner searched from the new ptr), else to IDLE.
- Round-robin rule: the requester with the lowest index i such that (ptr+i) mod N has req high wins.
- lock without req has no effect.
- Forced release does not skip the evicted requester. It keeps req high and is rescheduled after every higher-priority waiter has been served.
- bus is a combinational mux driven only by the registered gnt. Changing din never changes gnt.
- Reset (asserted at any time, including mid-ownership):
  - State goes to IDLE; gnt=0, gnt_valid=0, gnt_id=0, bus=0, handoff=0, ptr=0, hold_cnt=0.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the first edge that sees req may grant.

## Timing
- Grant latency from IDLE is 1 edge: req sampled high at edge k gives gnt high after edge k.
- Release latency:
  - Owner drops req before edge k → HANDOFF after edge k.
  - Next owner granted after edge k+1.
  - The bus is 0 for exactly one cycle between any two owners.
- With MAX_HOLD=M, an unlocked owner under contention holds gnt for exactly M cycles, provided the competing req was already high when the grant started.
- If a competitor arrives later, hold_cnt is already saturated, so release happens at the first edge that sees the competitor.
- Simultaneous owner req-drop and max-hold expiry produce a single HANDOFF; there is no double advance of ptr.
- With a single requester and req held high, the grant never expires, regardless of MAX_HOLD.
- ptr wraps from N-1 to 0.
- The sustainable rate is at most one owner change per 2 cycles.

## Test plan
- Reset: reset=0 with req=4'b1111 → gnt=0, bus=8'h00, gnt_id=0 throughout. Release reset, then 1 edge → gnt=4'b0001, bus=din[7:0].
- Round robin: N=4, req=4'b1111 held, MAX_HOLD=8, no lock → owners 0,1,2,3,0 in order. Each owner holds 8 cycles, each change is separated by one handoff cycle with bus=8'h00, and gnt is always one-hot or zero.
- Voluntary release: requester 2 alone with din2=8'hA5 → bus=8'hA5. Requester 2 drops req → handoff=1, bus=8'h00 for 1 cycle, then IDLE.
- Lock: owner 1 with lock[1]=1, req=4'b0011 for 20 cycles → gnt stays 4'b0010 for all 20 cycles. Drop lock[1] → HANDOFF within 1 edge (hold_cnt is saturated), then gnt=4'b0001.
- Mid-ownership reset: owner 3 granted, assert reset mid-cycle → gnt=0 and bus=0 immediately. Release with req=4'b1000 → gnt=4'b1000 after 1 edge, and ptr has been reset to 0.
- Simultaneous expiry: MAX_HOLD=2, owner 0 drops req on the same edge that its hold expires while req[1]=1 → exactly one handoff cycle, then gnt=4'b0010.
